// File: rtl/cen_frac_multi_if.sv
// Configuration and enable-output bundle for cen_frac_multi.
// The master side programs channels; the slave side is the generator.
interface cen_frac_multi_if #(
    parameter int CHANNELS = 4,
    parameter int ACC_W    = 16,
    parameter int SPD_W    = 2
) ();
    logic                cfg_wr;
    logic [2:0]          cfg_ch;
    logic [ACC_W-1:0]    cfg_num;
    logic [ACC_W-1:0]    cfg_den;
    logic [SPD_W-1:0]    speedup;
    logic                sync;
    logic [CHANNELS-1:0] cen;
    logic [CHANNELS-1:0] active;

    modport master (
        output cfg_wr, cfg_ch, cfg_num, cfg_den, speedup, sync,
        input  cen, active
    );

    modport slave (
        input  cfg_wr, cfg_ch, cfg_num, cfg_den, speedup, sync,
        output cen, active
    );
endinterface

// File: rtl/cen_frac_multi.sv
// Multi-channel fractional clock-enable generator: each channel pulses
// at clk_sys * (num << speedup) / den, saturating at every cycle.
module cen_frac_multi #(
    parameter int CHANNELS = 4,
    parameter int ACC_W    = 16,
    parameter int SPD_W    = 2
) (
    input logic clk_sys,
    input logic reset,
    cen_frac_multi_if.slave bus
);
    localparam int EFF_W = ACC_W + 2**SPD_W;
    localparam int SUM_W = ACC_W + 1;

    logic [CHANNELS-1:0] cen_vec;
    logic [CHANNELS-1:0] act_vec;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [ACC_W-1:0] num_q, num_d;
        logic [ACC_W-1:0] den_q, den_d;
        logic [ACC_W-1:0] acc_q, acc_d;
        logic             cen_q, cen_d;
        logic [EFF_W-1:0] eff_raw;
        logic [EFF_W-1:0] eff;
        logic [SUM_W-1:0] sum;
        logic [SUM_W-1:0] diff;
        logic             hit;

        always_comb begin
            hit     = bus.cfg_wr && (bus.cfg_ch == 3'(g));
            eff_raw = EFF_W'(num_q) << bus.speedup;
            // Clamp keeps eff <= den, so acc + eff never exceeds SUM_W bits
            eff     = (eff_raw >= EFF_W'(den_q)) ? EFF_W'(den_q) : eff_raw;
            sum     = {1'b0, acc_q} + SUM_W'(eff);
            diff    = sum - {1'b0, den_q};
            num_d   = num_q;
            den_d   = den_q;
            acc_d   = acc_q;
            cen_d   = 1'b0;
            if (hit) begin
                num_d = bus.cfg_num;
                den_d = bus.cfg_den;
                acc_d = '0;
            end else if (bus.sync) begin
                acc_d = '0;
            end else if (den_q != '0) begin
                if (sum >= {1'b0, den_q}) begin
                    acc_d = diff[ACC_W-1:0];
                    cen_d = 1'b1;
                end else begin
                    acc_d = sum[ACC_W-1:0];
                end
            end
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                num_q <= '0;
                den_q <= '0;
                acc_q <= '0;
                cen_q <= 1'b0;
            end else begin
                num_q <= num_d;
                den_q <= den_d;
                acc_q <= acc_d;
                cen_q <= cen_d;
            end
        end

        assign cen_vec[g] = cen_q;
        assign act_vec[g] = |den_q;
    end

    assign bus.cen    = cen_vec;
    assign bus.active = act_vec;
endmodule

// File: tb/tb_cen_frac_multi.sv
// Scoreboard bench for cen_frac_multi: a phase-total model predicts
// every cycle's cen/active, a monitor compares them at the falling edge.
module tb_cen_frac_multi;
    localparam int CH = 4;
    localparam int AW = 16;
    localparam int SW = 2;

    logic clk_sys = 1'b0;
    logic reset;
    always #5 clk_sys = ~clk_sys;

    cen_frac_multi_if #(.CHANNELS(CH), .ACC_W(AW), .SPD_W(SW)) bus ();

    cen_frac_multi #(.CHANNELS(CH), .ACC_W(AW), .SPD_W(SW)) dut (
        .clk_sys(clk_sys),
        .reset  (reset),
        .bus    (bus)
    );

    typedef struct {
        logic [CH-1:0] cen;
        logic [CH-1:0] act;
        bit            win;
    } exp_t;

    exp_t   q[$];
    exp_t   me;
    int     checks = 0;
    int     errors = 0;
    int     wcnt[CH];
    longint m_num[CH];
    longint m_den[CH];
    longint m_t[CH];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Model: total phase advance since the last clear; a pulse occurs
    // whenever floor(total/den) steps up.
    task automatic step(input bit r, input bit wr, input int ch,
                        input int n, input int d, input int spd,
                        input bit sy, input bit win);
        exp_t   e;
        longint eff;
        longint old;
        @(posedge clk_sys);
        #1;
        reset       = r;
        bus.cfg_wr  = wr;
        bus.cfg_ch  = 3'(ch);
        bus.cfg_num = 16'(n);
        bus.cfg_den = 16'(d);
        bus.speedup = 2'(spd);
        bus.sync    = sy;
        e.win = win;
        for (int c = 0; c < CH; c++) begin
            e.cen[c] = 1'b0;
            if (r) begin
                m_num[c] = 0;
                m_den[c] = 0;
                m_t[c]   = 0;
            end else if (wr && ch == c) begin
                m_num[c] = n;
                m_den[c] = d;
                m_t[c]   = 0;
            end else if (sy) begin
                m_t[c] = 0;
            end else if (m_den[c] != 0) begin
                eff = m_num[c] * (longint'(1) << spd);
                if (eff > m_den[c]) eff = m_den[c];
                old = m_t[c] / m_den[c];
                m_t[c] += eff;
                e.cen[c] = ((m_t[c] / m_den[c]) != old);
            end
            e.act[c] = (m_den[c] != 0);
        end
        q.push_back(e);
    endtask

    task automatic idle(input int k, input int spd, input bit win);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, spd, 0, win);
    endtask

    task automatic clr_win();
        for (int c = 0; c < CH; c++) wcnt[c] = 0;
    endtask

    initial begin
        forever begin
            @(posedge clk_sys);
            if (q.size() > 0) begin
                me = q.pop_front();
                @(negedge clk_sys);
                checks++;
                if (bus.cen !== me.cen || bus.active !== me.act) begin
                    errors++;
                    $display("FAIL cen_active: got cen=%b act=%b expected cen=%b act=%b",
                             bus.cen, bus.active, me.cen, me.act);
                end
                if (me.win)
                    for (int c = 0; c < CH; c++) wcnt[c] += int'(bus.cen[c]);
            end
        end
    end

    initial begin
        int n, d;
        reset       = 1'b1;
        bus.cfg_wr  = 1'b0;
        bus.cfg_ch  = '0;
        bus.cfg_num = '0;
        bus.cfg_den = '0;
        bus.speedup = '0;
        bus.sync    = 1'b0;
        for (int c = 0; c < CH; c++) begin
            m_num[c] = 0; m_den[c] = 0; m_t[c] = 0; wcnt[c] = 0;
        end
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);

        // ch0 = 1/4
        step(0, 1, 0, 1, 4, 0, 0, 0);
        clr_win();
        idle(100, 0, 1);
        idle(2, 0, 0);
        chk("ch0_1of4_100cyc", wcnt[0], 25);

        // ch1 = 3/8
        step(0, 1, 1, 3, 8, 0, 0, 0);
        clr_win();
        idle(1000, 0, 1);
        idle(2, 0, 0);
        chk("ch1_3of8_1000cyc", wcnt[1], 375);
        chk("ch0_1of4_1000cyc", wcnt[0], 250);

        // speedup sweep on ch0
        clr_win();
        idle(40, 1, 1);
        idle(2, 1, 0);
        chk("ch0_spd1_40cyc", wcnt[0], 20);
        clr_win();
        idle(10, 3, 1);
        idle(2, 3, 0);
        chk("ch0_spd3_clamp", wcnt[0], 10);
        clr_win();
        idle(40, 0, 1);
        idle(2, 0, 0);
        chk("ch0_spd0_back", wcnt[0], 10);

        // den=0 channel and out-of-range channel write
        step(0, 1, 2, 5, 0, 0, 0, 0);
        step(0, 1, 5, 3, 3, 0, 0, 0);
        step(0, 1, 7, 1, 1, 0, 0, 0);
        clr_win();
        idle(20, 0, 1);
        idle(2, 0, 0);
        chk("ch2_den0_quiet", wcnt[2], 0);
        chk("ch3_untouched", wcnt[3], 0);

        // sync alignment with dens 5 and 7
        step(0, 1, 0, 1, 5, 0, 0, 0);
        step(0, 1, 1, 1, 7, 0, 0, 0);
        idle(23, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        clr_win();
        idle(35, 0, 1);
        idle(2, 0, 0);
        chk("ch0_post_sync", wcnt[0], 7);
        chk("ch1_post_sync", wcnt[1], 5);

        // sync and cfg_wr together
        step(0, 1, 3, 2, 9, 0, 1, 0);
        idle(30, 0, 0);

        // reset mid-run with a simultaneous write
        step(1, 1, 3, 1, 2, 0, 0, 0);
        clr_win();
        idle(10, 0, 1);
        idle(2, 0, 0);
        chk("post_reset_quiet", wcnt[0] + wcnt[1] + wcnt[2] + wcnt[3], 0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            d = int'($urandom_range(20));
            if ($urandom_range(9) == 0) d = int'($urandom_range(65535));
            n = int'($urandom_range(d + 4));
            if (n > 65535) n = 65535;
            step($urandom_range(99) == 0, $urandom_range(3) == 0,
                 int'($urandom_range(7)), n, d, int'($urandom_range(3)),
                 $urandom_range(19) == 0, 0);
        end

        idle(3, 0, 0);
        @(posedge clk_sys);
        @(negedge clk_sys);
        #1;
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
